// File: rtl/vga_pattern_core.sv
// Parametrised video timing generator with four runtime-selectable test patterns.
// Optional build macro PATTERN_SCROLL_EN adds a per-frame horizontal scroll of patterns 0-2.
module vga_pattern_core #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIX_SZ    = 4,
  parameter int BAR_COUNT = 8,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HSZ      = $clog2(H_TOTAL),
  localparam int VSZ      = $clog2(V_TOTAL)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic [1:0]        mode_i,
  output logic [PIX_SZ-1:0] o_r,
  output logic [PIX_SZ-1:0] o_g,
  output logic [PIX_SZ-1:0] o_b,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic [HSZ-1:0]    hcount_o,
  output logic [VSZ-1:0]    vcount_o,
  output logic [7:0]        frame_o,
  output logic              sof_o
);
  localparam int BAR_W = H_ACTIVE / BAR_COUNT;

  logic [HSZ-1:0]    h_q, h_d;
  logic [VSZ-1:0]    v_q, v_d;
  logic [1:0]        mode_q, mode_d;
  logic              wrap_q, wrap_d;
  logic [7:0]        frame_q, frame_d;
  logic [PIX_SZ-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d, sof_q, sof_d;
  logic [HSZ-1:0]    hc_q, hc_d;
  logic [VSZ-1:0]    vc_q, vc_d;

  logic [31:0]       hw, vw, xw;
  logic              h_last, v_last, at_origin, de, hs_act, vs_act, grid;
  logic [1:0]        mode_eff;
  logic [HSZ-1:0]    x_eff;
  logic [2:0]        k, c;
  logic [PIX_SZ-1:0] pr, pg, pb;

  always_comb begin
    hw        = 32'(h_q);
    vw        = 32'(v_q);
    h_last    = (hw == 32'(H_TOTAL - 1));
    v_last    = (vw == 32'(V_TOTAL - 1));
    at_origin = (hw == 32'd0) && (vw == 32'd0);
    de        = (hw < 32'(H_ACTIVE)) && (vw < 32'(V_ACTIVE));
    hs_act    = (hw >= 32'(H_ACTIVE + H_FP)) && (hw < 32'(H_ACTIVE + H_FP + H_SYNC));
    vs_act    = (vw >= 32'(V_ACTIVE + V_FP)) && (vw < 32'(V_ACTIVE + V_FP + V_SYNC));
    // The pixel at the frame origin already uses the newly latched mode
    mode_eff  = at_origin ? mode_i : mode_q;
  end

`ifdef PATTERN_SCROLL_EN
  logic [HSZ-1:0] off_q, off_d;
  logic [HSZ:0]   xs;

  // Offset advances together with the frame counter so it is constant within a frame
  always_comb begin
    off_d = off_q;
    if (en_i && at_origin && wrap_q)
      off_d = (32'(off_q) == 32'(H_ACTIVE - 1)) ? '0 : off_q + HSZ'(1);
    xs    = {1'b0, h_q} + {1'b0, off_d};
    x_eff = (32'(xs) >= 32'(H_ACTIVE)) ? HSZ'(32'(xs) - 32'(H_ACTIVE)) : xs[HSZ-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) off_q <= '0;
    else         off_q <= off_d;
  end
`else
  always_comb x_eff = h_q;
`endif

  // Bar index by constant comparator chain; only k mod 8 matters for colour
  always_comb begin
    xw = 32'(x_eff);
    k  = '0;
    for (int i = 1; i < BAR_COUNT; i++)
      if (xw >= 32'(i * BAR_W)) k = 3'(i);
    c    = ~k;
    grid = (xw[4:0] == 5'd0) || (vw[4:0] == 5'd0) ||
           (xw == 32'(H_ACTIVE - 1)) || (vw == 32'(V_ACTIVE - 1));
    pr = '0;
    pg = '0;
    pb = '0;
    case (mode_eff)
      2'd0: begin
        pr = c[2] ? '1 : '0;
        pg = c[1] ? '1 : '0;
        pb = c[0] ? '1 : '0;
      end
      2'd1: begin
        pr = grid ? '1 : '0;
        pg = grid ? '1 : '0;
        pb = grid ? '1 : '0;
      end
      2'd2: begin
        pr = x_eff[HSZ-1 -: PIX_SZ];
        pg = v_q[VSZ-1 -: PIX_SZ];
      end
      default: begin
        pr = {1'b1, {(PIX_SZ-1){1'b0}}};
        pg = {1'b1, {(PIX_SZ-1){1'b0}}};
        pb = {1'b1, {(PIX_SZ-1){1'b0}}};
      end
    endcase
  end

  always_comb begin
    h_d     = '0;
    v_d     = '0;
    wrap_d  = 1'b0;
    mode_d  = mode_q;
    frame_d = frame_q;
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    hs_d    = ~HSYNC_POL;
    vs_d    = ~VSYNC_POL;
    de_d    = 1'b0;
    sof_d   = 1'b0;
    hc_d    = '0;
    vc_d    = '0;
    if (en_i) begin
      h_d    = h_last ? '0 : h_q + HSZ'(1);
      v_d    = h_last ? (v_last ? '0 : v_q + VSZ'(1)) : v_q;
      wrap_d = h_last && v_last;
      if (at_origin) begin
        mode_d = mode_i;
        // Only a real wrap counts; the first frame after reset/enable stays put
        if (wrap_q) frame_d = frame_q + 8'd1;
      end
      r_d   = de ? pr : '0;
      g_d   = de ? pg : '0;
      b_d   = de ? pb : '0;
      hs_d  = hs_act ? HSYNC_POL : ~HSYNC_POL;
      vs_d  = vs_act ? VSYNC_POL : ~VSYNC_POL;
      de_d  = de;
      sof_d = at_origin;
      hc_d  = h_q;
      vc_d  = v_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      h_q     <= '0;
      v_q     <= '0;
      wrap_q  <= 1'b0;
      mode_q  <= '0;
      frame_q <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= ~HSYNC_POL;
      vs_q    <= ~VSYNC_POL;
      de_q    <= 1'b0;
      sof_q   <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      wrap_q  <= wrap_d;
      mode_q  <= mode_d;
      frame_q <= frame_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      sof_q   <= sof_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
    end
  end

  assign o_r      = r_q;
  assign o_g      = g_q;
  assign o_b      = b_q;
  assign o_hsync  = hs_q;
  assign o_vsync  = vs_q;
  assign o_de     = de_q;
  assign hcount_o = hc_q;
  assign vcount_o = vc_q;
  assign frame_o  = frame_q;
  assign sof_o    = sof_q;
endmodule
